// File: rtl/rx_chan_arbiter.sv
// Round-robin drain scheduler: pulls bytes from NUM_CH UART receivers onto one valid/ready stream.
// Optional RX_ARB_DROP_FERR_EN: discard framing-error bytes and count them on drop_cnt.
module rx_chan_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [NUM_CH-1:0]   ch_data_ready,
    input  logic [8*NUM_CH-1:0] ch_rx_data,
    input  logic [NUM_CH-1:0]   ch_framing_error,
    input  logic [NUM_CH-1:0]   ch_overrun_error,
    output logic [NUM_CH-1:0]   ch_data_read,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_err,
    output logic [NUM_CH-1:0]   ovr_flags,
    input  logic [NUM_CH-1:0]   ovr_clr
`ifdef RX_ARB_DROP_FERR_EN
    ,
    output logic [7:0]          drop_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_reg;
    logic [CH_W-1:0]   ptr_reg;
    logic [NUM_CH-1:0] ch_data_read_reg;
    logic              out_valid_reg;
    logic [7:0]        out_data_reg;
    logic [CH_W-1:0]   out_ch_reg;
    logic              out_err_reg;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [CH_W-1:0]   sel;
    logic [7:0]        rx_byte [NUM_CH];

    assign req     = ch_data_ready & ch_enable;
    assign any_req = |req;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic ovr_reg;

            assign rx_byte[gi]   = ch_rx_data[8*gi +: 8];
            assign ovr_flags[gi] = ovr_reg;

            // Set has priority so an overrun landing on a clear is never lost.
            always_ff @(posedge clk) begin
                if (n_rst)
                    ovr_reg <= 1'b0;
                else if (ch_overrun_error[gi])
                    ovr_reg <= 1'b1;
                else if (ovr_clr[gi])
                    ovr_reg <= 1'b0;
            end
        end
    endgenerate

    // Scan downward in distance so the nearest requester after the pointer wins.
    always_comb begin
        logic [CH_W-1:0] cand;
        sel  = '0;
        cand = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CH_W'((int'(ptr_reg) + k) % NUM_CH);
            if (req[cand])
                sel = cand;
        end
    end

`ifdef RX_ARB_DROP_FERR_EN
    logic [7:0] drop_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
`endif

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_reg        <= ST_IDLE;
            ptr_reg          <= CH_W'(NUM_CH - 1);
            ch_data_read_reg <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= 8'h00;
            out_ch_reg       <= '0;
            out_err_reg      <= 1'b0;
`ifdef RX_ARB_DROP_FERR_EN
            drop_cnt_reg     <= 8'h00;
`endif
        end else begin
            ch_data_read_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        out_data_reg     <= rx_byte[sel];
                        out_ch_reg       <= sel;
                        ch_data_read_reg <= NUM_CH'(1) << sel;
                        ptr_reg          <= sel;
                        state_reg        <= ST_HOLD;
`ifdef RX_ARB_DROP_FERR_EN
                        out_err_reg      <= 1'b0;
                        // Dropped bytes still spend one HOLD cycle so the receiver can clear ready.
                        if (ch_framing_error[sel]) begin
                            out_valid_reg <= 1'b0;
                            if (drop_cnt_reg != 8'hFF)
                                drop_cnt_reg <= drop_cnt_reg + 8'd1;
                        end else begin
                            out_valid_reg <= 1'b1;
                        end
`else
                        out_err_reg      <= ch_framing_error[sel];
                        out_valid_reg    <= 1'b1;
`endif
                    end
                end
                ST_HOLD: begin
                    if (!out_valid_reg || out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ch_data_read = ch_data_read_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_ch       = out_ch_reg;
    assign out_err      = out_err_reg;

endmodule

// File: tb/tb_rx_chan_arbiter.sv
// Self-checking bench for rx_chan_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_rx_chan_arbiter;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                clk = 1'b0;
    logic                n_rst = 1'b1;
    logic [NUM_CH-1:0]   ch_enable = '1;
    logic [NUM_CH-1:0]   ch_data_ready = '0;
    logic [8*NUM_CH-1:0] ch_rx_data = '0;
    logic [NUM_CH-1:0]   ch_framing_error = '0;
    logic [NUM_CH-1:0]   ch_overrun_error = '0;
    logic [NUM_CH-1:0]   ch_data_read;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [7:0]          out_data;
    logic [CH_W-1:0]     out_ch;
    logic                out_err;
    logic [NUM_CH-1:0]   ovr_flags;
    logic [NUM_CH-1:0]   ovr_clr = '0;
`ifdef RX_ARB_DROP_FERR_EN
    logic [7:0]          drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [8:0] q [NUM_CH][$];   // receiver buffers: {framing_error, byte}

    rx_chan_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .n_rst(n_rst), .ch_enable(ch_enable), .ch_data_ready(ch_data_ready),
        .ch_rx_data(ch_rx_data), .ch_framing_error(ch_framing_error),
        .ch_overrun_error(ch_overrun_error), .ch_data_read(ch_data_read),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_err(out_err), .ovr_flags(ovr_flags), .ovr_clr(ovr_clr)
`ifdef RX_ARB_DROP_FERR_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_rx();
        for (int i = 0; i < NUM_CH; i++) begin
            if (q[i].size() > 0) begin
                ch_data_ready[i]      = 1'b1;
                ch_rx_data[8*i +: 8]  = q[i][0][7:0];
                ch_framing_error[i]   = q[i][0][8];
            end else begin
                ch_data_ready[i]      = 1'b0;
                ch_rx_data[8*i +: 8]  = 8'h00;
                ch_framing_error[i]   = 1'b0;
            end
        end
    endtask

    // Receiver model: a data_read seen at an edge drops the head byte on that edge.
    task automatic step();
        logic [NUM_CH-1:0] rd;
        rd = ch_data_read;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++)
            if (rd[i] && q[i].size() > 0) void'(q[i].pop_front());
        drive_rx();
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        step();
        step();
        n_rst = 1'b0;
    endtask

    function automatic int rr_pick(input logic [NUM_CH-1:0] r, input int last);
        for (int k = 1; k <= NUM_CH; k++)
            if (r[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        q[3].push_back({1'b0, 8'h5A});
        ch_overrun_error = 4'b0010;
        drive_rx();
        step();
        ch_overrun_error = '0;
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL reset_pre_grant: valid=%b ch=%0d want valid=1 ch=3", out_valid, out_ch);
        end
        n_rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || ch_data_read !== 4'b0000 || out_data !== 8'h00 ||
            out_ch !== 2'd0 || out_err !== 1'b0 || ovr_flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_values: valid=%b rd=%b data=%h ch=%0d err=%b ovr=%b want all zero",
                     out_valid, ch_data_read, out_data, out_ch, out_err, ovr_flags);
        end
`ifdef RX_ARB_DROP_FERR_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        step();
        n_rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || ch_data_read !== 4'b0000) begin
                errors++;
                $display("FAIL idle_quiet cyc%0d: valid=%b rd=%b want 0/0000", c, out_valid, ch_data_read);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        q[1].push_back({1'b0, 8'hA5});
        drive_rx();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd1 || ch_data_read !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: valid=%b data=%h ch=%0d rd=%b want 1 a5 1 0010",
                     out_valid, out_data, out_ch, ch_data_read);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || ch_data_read !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: valid=%b rd=%b want 0 0000", out_valid, ch_data_read);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ch_data_read !== 4'b0000) begin
                errors++;
                $display("FAIL single_no_regrant: rd=%b want 0000", ch_data_read);
            end
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        int gcnt, last_cyc;
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_CH; i++)
                q[i].push_back({1'b0, 8'(8'h10 + 8'h11 * i + 8'h80 * r)});
        drive_rx();
        gcnt = 0;
        last_cyc = -2;
        for (int cyc = 0; cyc < 40 && gcnt < 8; cyc++) begin
            step();
            if (ch_data_read !== 4'b0000) begin
                logic [NUM_CH-1:0] oh;
                logic [7:0] eb;
                oh = '0;
                oh[gcnt % NUM_CH] = 1'b1;
                eb = 8'(8'h10 + 8'h11 * (gcnt % NUM_CH) + 8'h80 * (gcnt / NUM_CH));
                checks++;
                if (ch_data_read !== oh || out_ch !== CH_W'(gcnt % NUM_CH) || out_data !== eb ||
                    out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_grant%0d: rd=%b ch=%0d data=%h valid=%b want rd=%b ch=%0d data=%h",
                             gcnt, ch_data_read, out_ch, out_data, out_valid, oh, gcnt % NUM_CH, eb);
                end
                checks++;
                if ((gcnt == 0 && cyc != 0) || (gcnt > 0 && cyc - last_cyc != 2)) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: grant at cycle %0d prev %0d want spacing 2", gcnt, cyc, last_cyc);
                end
                last_cyc = cyc;
                gcnt++;
            end
        end
        checks++;
        if (gcnt != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d grants want 8", gcnt);
        end
        step();
        $display("test_round_robin done");
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        q[2].push_back({1'b0, 8'h3C});
        drive_rx();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h3C || ch_data_read !== 4'b0100) begin
            errors++;
            $display("FAIL hold_grant: valid=%b ch=%0d data=%h rd=%b want 1 2 3c 0100",
                     out_valid, out_ch, out_data, ch_data_read);
        end
        q[0].push_back({1'b0, 8'h11});
        ch_enable = 4'b1011;
        drive_rx();
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h3C || ch_data_read !== 4'b0000) begin
                errors++;
                $display("FAIL hold_stable cyc%0d: valid=%b ch=%0d data=%h rd=%b want 1 2 3c 0000",
                         c, out_valid, out_ch, out_data, ch_data_read);
            end
        end
        out_ready = 1'b1;
        ch_enable = '1;
        step();
        checks++;
        if (out_valid !== 1'b0 || ch_data_read !== 4'b0000) begin
            errors++;
            $display("FAIL hold_release: valid=%b rd=%b want 0 0000", out_valid, ch_data_read);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11 || ch_data_read !== 4'b0001) begin
            errors++;
            $display("FAIL hold_next: valid=%b ch=%0d data=%h rd=%b want 1 0 11 0001",
                     out_valid, out_ch, out_data, ch_data_read);
        end
        step();
        step();
        $display("test_hold done");
    endtask

    task automatic test_overrun();
        logic [NUM_CH-1:0] want [5];
        logic [NUM_CH-1:0] err_seq [5];
        logic [NUM_CH-1:0] clr_seq [5];
        err_seq = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        clr_seq = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
        want    = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        for (int s = 0; s < 5; s++) begin
            ch_overrun_error = err_seq[s];
            ovr_clr = clr_seq[s];
            step();
            checks++;
            if (ovr_flags !== want[s]) begin
                errors++;
                $display("FAIL ovr_step%0d: got %b want %b", s, ovr_flags, want[s]);
            end
        end
        ch_overrun_error = '0;
        ovr_clr = '0;
        $display("test_overrun done");
    endtask

    task automatic test_ferr();
        out_ready = 1'b1;
        q[0].push_back({1'b1, 8'h7E});
        drive_rx();
        step();
`ifdef RX_ARB_DROP_FERR_EN
        checks++;
        if (out_valid !== 1'b0 || ch_data_read !== 4'b0001 || drop_cnt !== 8'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_drop: valid=%b rd=%b drop=%0d err=%b want 0 0001 1 0",
                     out_valid, ch_data_read, drop_cnt, out_err);
        end
`else
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7E || out_err !== 1'b1 || ch_data_read !== 4'b0001) begin
            errors++;
            $display("FAIL ferr_fwd: valid=%b data=%h err=%b rd=%b want 1 7e 1 0001",
                     out_valid, out_data, out_err, ch_data_read);
        end
`endif
        step();
        checks++;
        if (out_valid !== 1'b0 || ch_data_read !== 4'b0000) begin
            errors++;
            $display("FAIL ferr_after: valid=%b rd=%b want 0 0000", out_valid, ch_data_read);
        end
        step();
        $display("test_ferr done");
    endtask

    // Transaction-level model: at most one byte is "in flight" between a grant and its hand-off.
    task automatic test_random();
        int last, c;
        logic busy, mvalid, merr;
        logic [7:0] mdata, mdrop;
        logic [CH_W-1:0] mch;
        logic [NUM_CH-1:0] req, exp_rd, ovr_exp;
        bit draining;
        int drain_cyc;
        do_reset();
        last = NUM_CH - 1;
        busy = 1'b0; mvalid = 1'b0; merr = 1'b0; mdata = 8'h00; mch = '0;
        mdrop = 8'd0; ovr_exp = '0;
        draining = 1'b0; drain_cyc = 0;
        for (int cyc = 0; cyc < 3300; cyc++) begin
            if (cyc < 3000) begin
                if ($urandom_range(3) == 0) begin
                    c = $urandom_range(NUM_CH - 1);
                    if (q[c].size() < 3) q[c].push_back({($urandom_range(7) == 0), 8'($urandom)});
                end
                for (int i = 0; i < NUM_CH; i++)
                    if ($urandom_range(15) == 0) ch_enable[i] = ~ch_enable[i];
                out_ready = ($urandom_range(2) != 0);
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_overrun_error[i] = ($urandom_range(15) == 0);
                    ovr_clr[i] = ($urandom_range(15) == 0);
                end
            end else begin
                draining = 1'b1;
                ch_enable = '1; out_ready = 1'b1; ch_overrun_error = '0; ovr_clr = '1;
            end
            drive_rx();
            req = ch_enable & ch_data_ready;
            exp_rd = '0;
            if (!busy) begin
                if (req != '0) begin
                    c = rr_pick(req, last);
                    last = c;
                    exp_rd[c] = 1'b1;
                    mch = CH_W'(c);
                    mdata = q[c][0][7:0];
                    merr = q[c][0][8];
                    busy = 1'b1;
`ifdef RX_ARB_DROP_FERR_EN
                    if (merr) begin
                        mvalid = 1'b0;
                        if (mdrop != 8'hFF) mdrop = mdrop + 8'd1;
                    end else begin
                        mvalid = 1'b1;
                    end
                    merr = 1'b0;
`else
                    mvalid = 1'b1;
`endif
                end
            end else if (!mvalid) begin
                busy = 1'b0;
            end else if (out_ready) begin
                busy = 1'b0;
                mvalid = 1'b0;
            end
            ovr_exp = (ovr_exp & ~ovr_clr) | ch_overrun_error;
            step();
            checks++;
            if (ch_data_read !== exp_rd || out_valid !== mvalid || ovr_flags !== ovr_exp ||
                (mvalid && (out_data !== mdata || out_ch !== mch || out_err !== merr))) begin
                errors++;
                $display("FAIL rand cyc%0d: rd=%b valid=%b data=%h ch=%0d err=%b ovr=%b want rd=%b valid=%b data=%h ch=%0d err=%b ovr=%b",
                         cyc, ch_data_read, out_valid, out_data, out_ch, out_err, ovr_flags,
                         exp_rd, mvalid, mdata, mch, merr, ovr_exp);
            end
`ifdef RX_ARB_DROP_FERR_EN
            checks++;
            if (drop_cnt !== mdrop) begin
                errors++;
                $display("FAIL rand_drop cyc%0d: got %0d want %0d", cyc, drop_cnt, mdrop);
            end
`endif
            if (draining) drain_cyc++;
        end
        checks++;
        if (q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0 || busy) begin
            errors++;
            $display("FAIL rand_drain: %0d bytes left busy=%b after %0d drain cycles want 0",
                     q[0].size() + q[1].size() + q[2].size() + q[3].size(), busy, drain_cyc);
        end
        ovr_clr = '0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_overrun();
        test_ferr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_chan_arbiter.md
Name: rx_chan_arbiter

Overview:
- Round-robin drain scheduler for NUM_CH UART receive channels, each a receiver block with a data_ready / data_read / rx_data buffer interface.
- Pulls one byte at a time from whichever channels hold data and forwards it on a single valid/ready output stream, tagged with its channel index.
- Keeps sticky per-channel overrun flags so software sees lost bytes.
- Sits between the receiver array and the shared downstream consumer (FIFO or bus interface).

Parameters:
- NUM_CH, 4, number of receiver channels (2..8).
- CH_W, 2, channel index width; must equal ceil(log2(NUM_CH)).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset; synchronous, active-high (asserted = 1, sampled on rising clk).
- ch_enable  input  NUM_CH  per-channel arbitration enable.
- ch_data_ready  input  NUM_CH  receiver buffer holds an unread byte.
- ch_rx_data  input  8*NUM_CH  receiver bytes; channel i occupies bits [8i+7:8i].
- ch_framing_error  input  NUM_CH  receiver framing error status.
- ch_overrun_error  input  NUM_CH  receiver overrun status.
- ch_data_read  output  NUM_CH  one-cycle read strobe back to the granted receiver.
- out_valid  output  1  output byte valid.
- out_ready  input  1  consumer accepts the byte.
- out_data  output  8  forwarded byte.
- out_ch  output  CH_W  source channel of out_data.
- out_err  output  1  framing_error of the source channel at capture time.
- ovr_flags  output  NUM_CH  sticky overrun flags.
- ovr_clr  input  NUM_CH  per-bit clear of ovr_flags.

Behaviour:
- Reset values (n_rst=1 at an edge):
  - ch_data_read=0, out_valid=0, out_data=0, out_ch=0, out_err=0, ovr_flags=0.
  - State=IDLE; last-grant pointer=NUM_CH-1, so channel 0 has first priority.
- Reset mid-operation: any held byte is discarded with no further ch_data_read pulse.
- Requests: req[i] = ch_data_ready[i] & ch_enable[i].
- FSM states: IDLE, HOLD.
- IDLE:
  - If any req, select the first requesting channel searching from pointer+1 upward, wrapping modulo NUM_CH.
  - At the next edge: register out_data, out_ch and out_err from the selected channel; set out_valid=1; set ch_data_read[sel]=1 for exactly one cycle; pointer=sel; state=HOLD.
  - Latency: req high in cycle T gives out_valid and ch_data_read high in cycle T+1.
- HOLD:
  - out_data, out_ch and out_err stay stable; out_valid=1.
  - ch_data_read=0 after its single cycle.
  - On an edge with out_ready=1: out_valid=0 and state=IDLE.
  - No new grant is evaluated in the cycle the transfer completes.
  - Minimum spacing between grants is 2 cycles; maximum throughput is 1 byte per 2 cycles.
- Stale-ready safety: the receiver clears data_ready on the edge after it samples data_read, so the next IDLE evaluation never re-grants the same byte.
- ch_enable deasserted while a channel is in HOLD: the transfer completes normally; enable gates new grants only.
- Single requester: it is granted on every IDLE opportunity.
- All channels requesting continuously: grants rotate strictly 0,1,2,3,0,...
- ovr_flags[i]:
  - Set on any edge where ch_overrun_error[i]=1.
  - Cleared on an edge where ovr_clr[i]=1.
  - If set and clear coincide, set wins.
- out_ready asserted while out_valid=0 is ignored.

Optional Feature:
- Macro RX_ARB_DROP_FERR_EN.
- Defined:
  - A byte captured with the channel framing_error=1 is still read (ch_data_read pulses) but is discarded: out_valid stays 0 and state returns to IDLE the following cycle.
  - out_err is tied 0.
  - An extra output drop_cnt (8 bits, saturating at 255, reset 0) counts discarded bytes.
- Undefined: every byte is forwarded with out_err reflecting framing status, and there is no drop_cnt port.

Test Plan:
- Reset then idle, all ch_data_ready=0 -> out_valid=0, ch_data_read=0000 for 20 cycles.
- ch1 ready with 0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=1, ch_data_read=0010 for one cycle only; out_valid drops after one cycle.
- All four channels ready (0x10,0x21,0x32,0x43), held ready, out_ready=1 -> out_ch order 0,1,2,3,0 with matching bytes and a grant every 2 cycles.
- ch2 granted with out_ready=0 for 5 cycles -> out_data and out_ch stable, single ch_data_read pulse, no further grants until out_ready=1.
- ch3 overrun pulse, then ovr_clr[3] in the same cycle as a second overrun pulse -> ovr_flags=1000 and stays set; a later clear alone -> 0000.
- ch0 byte 0x7E with framing_error=1 -> out_err=1 and byte forwarded; with RX_ARB_DROP_FERR_EN defined, no out_valid and drop_cnt=1.
